// File: rtl/ram_loader.sv
`default_nettype none
// ram_loader: streams DEPTH bytes plus a checksum into an external RAM, reads them back
// to verify, and hands the RAM to the CPU port when idle or verified.  Revision 1.0
module ram_loader #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_n_ce,
  output logic          cpu_grant,
  output logic          ram_prog_mode,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_din,
  output logic          ram_n_ce,
  input  logic [DW-1:0] ram_dout,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CHK    = 3'd2,
    VERIFY = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  localparam logic [AW:0] c_LAST    = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] c_PTR_ONE = (AW+1)'(1);

  state_t        r_state, w_state_nxt;
  logic [AW:0]   r_ptr, w_ptr_nxt;
  logic [DW-1:0] r_exp, w_exp_nxt;
  logic [DW-1:0] r_wsum, w_wsum_nxt;
  logic [DW-1:0] r_rsum, w_rsum_nxt;
  logic [DW-1:0] w_rsum_add;
  logic          r_busy, r_done, r_err;

  assign w_rsum_add = r_rsum + ram_dout;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_exp_nxt     = r_exp;
    w_wsum_nxt    = r_wsum;
    w_rsum_nxt    = r_rsum;
    in_ready      = 1'b0;
    cpu_grant     = 1'b0;
    ram_prog_mode = 1'b0;
    ram_address   = '0;
    ram_din       = '0;
    ram_n_ce      = 1'b1;

    case (r_state)
      IDLE, DONE, ERR: begin
        if (r_state != ERR) begin
          cpu_grant   = 1'b1;
          ram_address = cpu_addr;
          ram_n_ce    = cpu_n_ce;
        end
        if (start) begin
          w_ptr_nxt   = '0;
          w_wsum_nxt  = '0;
          w_rsum_nxt  = '0;
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        in_ready      = 1'b1;
        ram_prog_mode = in_valid;
        ram_address   = r_ptr[AW-1:0];
        ram_din       = in_data;
        if (in_valid) begin
          w_wsum_nxt = r_wsum + in_data;
          if (r_ptr == c_LAST) begin
            w_ptr_nxt   = '0;
            w_state_nxt = CHK;
          end else begin
            w_ptr_nxt = r_ptr + c_PTR_ONE;
          end
        end
      end
      CHK: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_exp_nxt   = in_data;
          w_state_nxt = VERIFY;
        end
      end
      VERIFY: begin
        ram_n_ce    = 1'b0;
        ram_address = r_ptr[AW-1:0];
        w_rsum_nxt  = w_rsum_add;
        w_ptr_nxt   = r_ptr + c_PTR_ONE;
        // Pass needs the readback to agree with both the sender's checksum and what was written.
        if (r_ptr == c_LAST) begin
          w_state_nxt = (w_rsum_add == r_exp && w_rsum_add == r_wsum) ? DONE : ERR;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_ptr  <= '0;
      r_exp  <= '0;
      r_wsum <= '0;
      r_rsum <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_ptr  <= w_ptr_nxt;
      r_exp  <= w_exp_nxt;
      r_wsum <= w_wsum_nxt;
      r_rsum <= w_rsum_nxt;
      // Status flags are decoded from the next state so they line up with r_state.
      r_busy <= (w_state_nxt == LOAD) || (w_state_nxt == CHK) || (w_state_nxt == VERIFY);
      r_done <= (w_state_nxt == DONE);
      r_err  <= (w_state_nxt == ERR);
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ram_loader.sv
`default_nettype none
// tb_ram_loader: drives load sequences into ram_loader against a behavioural RAM and checksum model.
module tb_ram_loader;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic [3:0] cpu_addr = 4'h0;
  logic       cpu_n_ce = 1'b1;
  logic       cpu_grant;
  logic       ram_prog_mode;
  logic [3:0] ram_address;
  logic [7:0] ram_din;
  logic       ram_n_ce;
  logic [7:0] ram_dout;
  logic       busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem [16];
  logic [3:0] wr_addr [$];
  logic [7:0] wr_data [$];
  int         vcnt = 0;
  int         bad_wr = 0;

  ram_loader #(.DEPTH(16), .AW(4), .DW(8)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .cpu_addr(cpu_addr), .cpu_n_ce(cpu_n_ce), .cpu_grant(cpu_grant),
    .ram_prog_mode(ram_prog_mode), .ram_address(ram_address), .ram_din(ram_din),
    .ram_n_ce(ram_n_ce), .ram_dout(ram_dout), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign ram_dout = mem[ram_address];

  // Behavioural synchronous-write RAM plus write/verify observers.
  always @(posedge clk) begin
    if (ram_prog_mode) begin
      mem[ram_address] <= ram_din;
      wr_addr.push_back(ram_address);
      wr_data.push_back(ram_din);
      if (!in_valid) bad_wr++;
    end
    if (busy && !ram_n_ce) vcnt++;
  end

  task automatic do_load(input logic [7:0] d[16], input logic [7:0] ck, input bit toggle,
                         input bit poke, output bit tmo);
    int n = 0;
    int cyc = 0;
    bit ph = 1'b0;
    tmo = 1'b0;
    wr_addr.delete(); wr_data.delete(); vcnt = 0; bad_wr = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (n < 17 && cyc < 100) begin
      if (toggle && ph) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        in_data  = (n < 16) ? d[n] : ck;
      end
      ph = ~ph;
      @(posedge clk);
      if (in_valid) n++;
      @(negedge clk); cyc++;
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    cyc = 0;
    while (!(done || err) && cyc < 60) begin
      start = poke && (cyc == 4);
      @(negedge clk); cyc++;
    end
    start = 1'b0;
    if (!(done || err)) tmo = 1'b1;
  endtask

  function automatic logic [7:0] model_sum(input logic [7:0] d[16]);
    int s = 0;
    for (int i = 0; i < 16; i++) s += d[i];
    return 8'(s % 256);
  endfunction

  task automatic test_reset;
    repeat (3) @(negedge clk);
    #1;
    n_tests++; if ({busy, done, err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {busy, done, err}); end
    n_tests++; if (cpu_grant !== 1'b1) begin n_fail++; $display("FAIL reset_grant: got %b want 1", cpu_grant); end
    n_tests++; if ({ram_prog_mode, in_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_prog_ready: got %b want 00", {ram_prog_mode, in_ready}); end
    @(negedge clk); n_rst = 1'b1;
    @(negedge clk);
    n_tests++; if ({busy, done, err, cpu_grant} !== 4'b0001) begin n_fail++; $display("FAIL idle_after_reset: got %b want 0001", {busy, done, err, cpu_grant}); end
  endtask

  task automatic test_good_load;
    logic [7:0] d[16];
    bit tmo;
    for (int i = 0; i < 16; i++) d[i] = 8'(i + 1);
    do_load(d, 8'h88, 1'b0, 1'b0, tmo);
    n_tests++; if (tmo) begin n_fail++; $display("FAIL good_timeout: got no completion want done"); end
    n_tests++; if (wr_addr.size() !== 16) begin n_fail++; $display("FAIL good_wr_count: got %0d want 16", wr_addr.size()); end
    for (int i = 0; i < 16 && i < wr_addr.size(); i++) begin
      n_tests++;
      if (wr_addr[i] !== 4'(i) || wr_data[i] !== d[i]) begin
        n_fail++; $display("FAIL good_write%0d: got %h@%h want %h@%h", i, wr_data[i], wr_addr[i], d[i], 4'(i));
      end
    end
    n_tests++; if (vcnt !== 16) begin n_fail++; $display("FAIL good_verify_len: got %0d want 16", vcnt); end
    n_tests++; if ({done, err, cpu_grant, busy} !== 4'b1010) begin n_fail++; $display("FAIL good_status: got %b want 1010", {done, err, cpu_grant, busy}); end
  endtask

  task automatic test_cpu_read;
    @(negedge clk); cpu_addr = 4'd5; cpu_n_ce = 1'b0;
    #1;
    n_tests++; if (ram_address !== 4'd5) begin n_fail++; $display("FAIL cpu_addr: got %h want 5", ram_address); end
    n_tests++; if (ram_n_ce !== 1'b0) begin n_fail++; $display("FAIL cpu_nce: got %b want 0", ram_n_ce); end
    n_tests++; if (ram_dout !== 8'h06) begin n_fail++; $display("FAIL cpu_dout: got %h want 06", ram_dout); end
    n_tests++; if (ram_prog_mode !== 1'b0 || ram_din !== 8'h00) begin n_fail++; $display("FAIL cpu_nowrite: got %b/%h want 0/00", ram_prog_mode, ram_din); end
  endtask

  task automatic test_bad_checksum;
    logic [7:0] d[16];
    bit tmo;
    for (int i = 0; i < 16; i++) d[i] = 8'(i + 1);
    do_load(d, 8'h87, 1'b0, 1'b0, tmo);
    cpu_n_ce = 1'b0; cpu_addr = 4'd3;
    #1;
    n_tests++; if (tmo) begin n_fail++; $display("FAIL bad_timeout: got no completion want err"); end
    n_tests++; if ({err, done, cpu_grant, ram_n_ce} !== 4'b1001) begin n_fail++; $display("FAIL bad_status: got %b want 1001", {err, done, cpu_grant, ram_n_ce}); end
    cpu_n_ce = 1'b1; cpu_addr = 4'd0;
  endtask

  task automatic test_toggle_valid;
    logic [7:0] d[16];
    bit tmo;
    for (int i = 0; i < 16; i++) d[i] = 8'($urandom);
    do_load(d, model_sum(d), 1'b1, 1'b0, tmo);
    n_tests++; if (bad_wr !== 0) begin n_fail++; $display("FAIL toggle_idle_write: got %0d want 0", bad_wr); end
    n_tests++; if (wr_addr.size() !== 16) begin n_fail++; $display("FAIL toggle_wr_count: got %0d want 16", wr_addr.size()); end
    for (int i = 0; i < 16; i++) begin
      n_tests++; if (mem[i] !== d[i]) begin n_fail++; $display("FAIL toggle_mem%0d: got %h want %h", i, mem[i], d[i]); end
    end
    n_tests++; if (tmo || done !== 1'b1) begin n_fail++; $display("FAIL toggle_done: got %b want 1", done); end
  endtask

  task automatic test_start_in_verify;
    logic [7:0] d[16];
    bit tmo;
    for (int i = 0; i < 16; i++) d[i] = 8'($urandom);
    do_load(d, model_sum(d), 1'b0, 1'b1, tmo);
    n_tests++; if (vcnt !== 16) begin n_fail++; $display("FAIL poke_verify_len: got %0d want 16", vcnt); end
    n_tests++; if (tmo || {done, err} !== 2'b10) begin n_fail++; $display("FAIL poke_status: got %b want 10", {done, err}); end
    @(negedge clk); @(negedge clk);
    n_tests++; if ({busy, done} !== 2'b01) begin n_fail++; $display("FAIL poke_stays_done: got %b want 01", {busy, done}); end
  endtask

  task automatic test_reset_mid_load;
    logic [7:0] d[16];
    bit tmo;
    for (int i = 0; i < 16; i++) d[i] = 8'($urandom);
    wr_addr.delete(); wr_data.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = d[i];
      @(posedge clk);
    end
    #2 n_rst = 1'b0;
    #1;
    n_tests++; if ({busy, in_ready, ram_prog_mode, cpu_grant} !== 4'b0001) begin n_fail++; $display("FAIL rst_async: got %b want 0001", {busy, in_ready, ram_prog_mode, cpu_grant}); end
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (wr_addr.size() !== 7) begin n_fail++; $display("FAIL rst_wr_count: got %0d want 7", wr_addr.size()); end
    @(negedge clk); n_rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    n_tests++; if ({busy, done, err, cpu_grant} !== 4'b0001) begin n_fail++; $display("FAIL rst_release_idle: got %b want 0001", {busy, done, err, cpu_grant}); end
    do_load(d, model_sum(d), 1'b0, 1'b0, tmo);
    n_tests++; if (tmo || {done, err} !== 2'b10) begin n_fail++; $display("FAIL rst_reload: got %b want 10", {done, err}); end
  endtask

  task automatic test_random;
    logic [7:0] d[16];
    logic [7:0] ck;
    bit good, tmo;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 16; i++) d[i] = 8'($urandom);
      good = ($urandom_range(0, 1) == 1);
      ck = good ? model_sum(d) : model_sum(d) + 8'($urandom_range(1, 255));
      do_load(d, ck, bit'($urandom_range(0, 1)), 1'b0, tmo);
      n_tests++;
      if (tmo || done !== good || err !== !good) begin
        n_fail++; $display("FAIL rand%0d_result: got done=%b err=%b want done=%b err=%b", k, done, err, good, !good);
      end
      n_tests++; if (vcnt !== 16) begin n_fail++; $display("FAIL rand%0d_verify_len: got %0d want 16", k, vcnt); end
      for (int i = 0; i < 16; i++) begin
        n_tests++; if (mem[i] !== d[i]) begin n_fail++; $display("FAIL rand%0d_mem%0d: got %h want %h", k, i, mem[i], d[i]); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    test_reset();
    test_good_load();
    test_cpu_read();
    test_bad_checksum();
    test_toggle_valid();
    test_start_in_verify();
    test_reset_mid_load();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameters SHALL be:
- DEPTH, 16, number of RAM words
- AW, 4, address width
- DW, 8, data width
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on its rising edge
- n_rst, in, 1, reset; asynchronous, active-low
- start, in, 1, begin a load sequence
- in_valid, in, 1, load byte present
- in_data, in, DW, load byte
- in_ready, out, 1, loader accepts in_data this cycle
- cpu_addr, in, AW, CPU read address
- cpu_n_ce, in, 1, CPU read enable, active-low
- cpu_grant, out, 1, CPU path connected to RAM
- ram_prog_mode, out, 1, RAM write strobe, sampled on the RAM clock edge
- ram_address, out, AW, RAM address
- ram_din, out, DW, RAM write data
- ram_n_ce, out, 1, RAM output enable, active-low
- ram_dout, in, DW, RAM read data, combinational from ram_address
- busy, out, 1, sequence in progress
- done, out, 1, last load verified good
- err, out, 1, last load failed checksum

Function
REQ-003 FSM states SHALL be IDLE, LOAD, CHK, VERIFY, DONE and ERR; the state, a pointer ptr[AW:0], an expected checksum exp[DW-1:0], a write sum wsum and a read sum rsum SHALL be registered.
REQ-004 IDLE, DONE, ERR: start=1 SHALL clear ptr, wsum and rsum and move to LOAD on the next edge.
REQ-005 LOAD: in_ready=1, ram_prog_mode=in_valid, ram_address=ptr[AW-1:0], ram_din=in_data and ram_n_ce=1; these outputs SHALL be combinational from state and inputs.
REQ-006 LOAD: a handshake (in_valid & in_ready) at an edge SHALL write the byte into the RAM at that same edge, increment ptr, and add in_data to wsum modulo 2^DW.
REQ-007 LOAD: a handshake with ptr==DEPTH-1 SHALL move to CHK and reset ptr to 0; with in_valid=0 the FSM SHALL hold and no write SHALL occur.
REQ-008 CHK: in_ready=1 and ram_prog_mode=0; a handshake SHALL store in_data to exp and move to VERIFY.
REQ-009 VERIFY: in_ready=0, ram_n_ce=0, ram_prog_mode=0 and ram_address=ptr; each cycle SHALL add ram_dout to rsum and increment ptr; exactly DEPTH cycles SHALL elapse.
REQ-010 After the VERIFY cycle with ptr==DEPTH-1, the FSM SHALL move to DONE if the final rsum==exp and rsum==wsum, otherwise to ERR.
REQ-011 busy SHALL be 1 in LOAD, CHK and VERIFY; done SHALL be 1 only in DONE; err SHALL be 1 only in ERR; all three SHALL be registered from the state.
REQ-012 In IDLE and DONE, cpu_grant=1, ram_address=cpu_addr, ram_n_ce=cpu_n_ce, ram_prog_mode=0 and ram_din=0.
REQ-013 In ERR and all busy states, cpu_grant=0 and the CPU inputs SHALL be ignored; in ERR, ram_n_ce=1 and ram_prog_mode=0.
REQ-014 start SHALL be ignored while busy=1.
REQ-015 in_ready SHALL be 0 in IDLE, VERIFY, DONE and ERR; in_valid in those states SHALL be ignored.
REQ-016 ram_prog_mode SHALL never be 1 outside LOAD.
REQ-017 A full load SHALL take DEPTH+1 handshakes followed by DEPTH VERIFY cycles; done or err SHALL assert on the edge after the last VERIFY cycle.

Reset
REQ-018 n_rst=0 SHALL immediately (asynchronously) force state=IDLE and ptr, exp, wsum, rsum=0; busy, done and err SHALL be 0.
REQ-019 During reset, ram_prog_mode=0, in_ready=0 and cpu_grant=1 (IDLE passthrough); RAM contents SHALL be left unchanged.
REQ-020 Reset asserted mid-LOAD or mid-VERIFY SHALL abort the sequence with no further RAM write; release SHALL resume in IDLE.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Load bytes 0x01..0x10 then checksum 0x88 -> 16 writes at addresses 0..15; VERIFY lasts 16 cycles; done=1, err=0, cpu_grant=1.
- Same data with checksum 0x87 -> err=1, done=0, cpu_grant=0, ram_n_ce=1.
- In DONE, cpu_addr=5 and cpu_n_ce=0 -> ram_address=5, ram_n_ce=0, ram_dout=0x06.
- in_valid toggled 1/0 every cycle during LOAD -> exactly 16 writes to consecutive addresses; no write while in_valid=0.
- start pulsed during VERIFY -> ignored; sequence completes unchanged.
- n_rst dropped after the 7th byte -> immediate IDLE, busy=0; a new full load completes with done=1.
